multi_cycle_counter: RTL and testbench
======================================

// Module: multi_cycle_counter
// PURPOSE
//  Parametrised, multi-channel successor to the single 16-bit cycle counter. It keeps one
//  independent sequence-cycle count per approach or intersection channel, with a per-channel
//  clear, a wrap or saturate mode and a sticky overflow flag. A single-outstanding
//  request/valid/ready read port lets the controller or debug UART sample any channel.
// PARAMETERS
//  CHANNELS  4   number of independent counters (1..16)
//  WIDTH     16  counter width in bits (2..32)
//  SATURATE  0   0 = wrap to 0 at all-ones; 1 = hold at all-ones
//  IDX_W     4   rd_idx width; must satisfy 2**IDX_W >= CHANNELS
// PORTS
//  clk         in   1         clock, all state on rising edge
//  rst         in   1         asynchronous, active-high reset
//  cycle_tick  in   CHANNELS  bit i: one-cycle pulse, count one completed cycle on channel i
//  clr         in   CHANNELS  bit i: synchronous clear of count i and ovf i
//  ovf         out  CHANNELS  bit i: sticky, set when channel i wraps or saturates
//  rd_req      in   1         read request, sampled only in IDLE
//  rd_idx      in   IDX_W     channel to read, sampled with rd_req
//  rd_valid    out  1         rd_data/rd_err valid; held until rd_ready
//  rd_ready    in   1         consumer accepts the response
//  rd_data     out  WIDTH     snapshot of the selected count
//  rd_err      out  1         rd_idx >= CHANNELS (rd_data = 0)
// BEHAVIOUR
//  Reset: all counts, ovf, rd_valid, rd_data and rd_err are 0. FSM enters IDLE.
//   rst asserted mid-transaction drops rd_valid immediately (asynchronous).
//  Per channel i, each clock edge, in priority order:
//   - clr[i]=1: count<=0, ovf[i]<=0. A coincident tick is discarded.
//   - tick=1, count<max: count<=count+1.
//   - tick=1, count==2**WIDTH-1: SATURATE=0 -> count<=0; SATURATE=1 -> hold.
//     In both modes ovf[i]<=1 and stays set until clr[i] or rst.
//   - Otherwise count holds. Channels never interact; all may tick in the same cycle.
//  Read FSM, two states:
//   - IDLE: rd_valid=0. If rd_req=1 at an edge, latch rd_data = count[rd_idx] as registered
//     before that edge (the same-edge increment is not included) and go to RESP.
//     If rd_idx>=CHANNELS, latch rd_data=0 and rd_err=1.
//   - RESP: rd_valid=1; rd_data and rd_err are stable and frozen. Later count changes are
//     not reflected. rd_req is ignored. If rd_ready=1 at an edge, return to IDLE.
//   - Latency: rd_valid rises 1 cycle after rd_req is accepted. Minimum spacing between two
//     reads is 2 cycles (rd_req held high with rd_ready high gives a response every 2nd
//     cycle).
//   - rd_data and rd_err are not required to be 0 outside RESP. Benches check them only
//     while rd_valid=1.
//  Arithmetic: unsigned, modulo 2**WIDTH. No combinational path from inputs to outputs.
// CONFIGURATION
//  CYCCNT_THRESH_EN defined: adds ports
//   thresh  in   WIDTH     shared alarm threshold
//   alarm   out  CHANNELS  registered, alarm[i] = (thresh!=0) && (count[i] >= thresh)
//   alarm follows the count with 1 cycle latency. clr[i] drops alarm[i] on the next edge.
//   Reset value is 0.
//  CYCCNT_THRESH_EN undefined: thresh and alarm ports and their logic are absent.
//   All other behaviour is identical.
// TESTING
//  1. rst mid-count, and during RESP -> counts, ovf and rd_valid are 0 while rst is high.
//  2. CHANNELS=4, tick ch2 x5, read idx2 -> rd_valid after 1 cycle, rd_data=5, rd_err=0;
//     hold rd_ready=0 for 3 cycles with further ticks -> rd_data stays 5.
//  3. WIDTH=4, SATURATE=0: 16 ticks on ch0 -> count 0, ovf[0]=1.
//     SATURATE=1: 20 ticks -> count 15, ovf[0]=1. Then clr[0] -> count 0, ovf[0]=0.
//  4. clr[1] and tick[1] in the same cycle at count 7 -> count 0.
//     Ticks on all channels in the same cycle -> each channel increments by 1.
//  5. rd_idx=5 with CHANNELS=4 -> rd_err=1, rd_data=0.
//     rd_req held with rd_ready=1 -> responses every 2nd cycle.
//  6. CYCCNT_THRESH_EN, thresh=3: 3 ticks on ch3 -> alarm[3]=1 one cycle after count reaches 3.
//     thresh=0 -> alarm all 0.

Source files
------------

// File: rtl/multi_cycle_counter.sv
// Multi-channel cycle counter with per-channel clear, wrap/saturate and sticky overflow.
// Single-outstanding read port; optional threshold alarm under CYCCNT_THRESH_EN.
module multi_cycle_counter #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0,
  parameter int IDX_W    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] cycle_tick,
  input  logic [CHANNELS-1:0] clr,
  output logic [CHANNELS-1:0] ovf,
  input  logic                rd_req,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_err
`ifdef CYCCNT_THRESH_EN
  ,
  input  logic [WIDTH-1:0]    thresh,
  output logic [CHANNELS-1:0] alarm
`endif
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] ovf_q;
  logic [CHANNELS-1:0] ovf_d;

  state_t              state_q;
  state_t              state_d;
  logic                rd_valid_q;
  logic                rd_valid_d;
  logic [WIDTH-1:0]    rd_data_q;
  logic [WIDTH-1:0]    rd_data_d;
  logic                rd_err_q;
  logic                rd_err_d;

  logic [WIDTH-1:0]    sel_data;
  logic                sel_err;

  // Per-channel next count: clear beats tick, all-ones wraps or holds.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (clr[i]) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (cycle_tick[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
          if (SATURATE != 0) begin
            cnt_d[i] = cnt_q[i];
          end else begin
            cnt_d[i] = '0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Count and overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Read mux over the registered counts; out-of-range index reads as zero.
  always_comb begin
    sel_data = '0;
    sel_err  = !(int'(rd_idx) < CHANNELS);
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(rd_idx) == i) begin
        sel_data = cnt_q[i];
      end
    end
  end

  // Read FSM next state: snapshot on accept, freeze until consumed.
  always_comb begin
    state_d    = state_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;
    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          state_d    = RESP;
          rd_valid_d = 1'b1;
          rd_data_d  = sel_data;
          rd_err_d   = sel_err;
        end
      end
      RESP: begin
        if (rd_ready) begin
          state_d    = IDLE;
          rd_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        rd_valid_d = 1'b0;
      end
    endcase
  end

  // Read FSM state and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign ovf      = ovf_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;

`ifdef CYCCNT_THRESH_EN
  logic [CHANNELS-1:0] alarm_q;
  logic [CHANNELS-1:0] alarm_d;

  // Alarm trails the count by one cycle; a clear drops it at once.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      alarm_d[i] = !clr[i] && (thresh != '0) && (cnt_q[i] >= thresh);
    end
  end

  // Alarm register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_q <= '0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_multi_cycle_counter.sv
// Scoreboard bench: wrap and saturate instances share stimulus.
// Reference model applies the counter rules on plain integers.
module tb_multi_cycle_counter;

  localparam int CH   = 4;
  localparam int W    = 4;
  localparam int IW   = 3;
  localparam int MAXV = (1 << W) - 1;

  typedef struct {
    int d0;
    int d1;
    bit err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] cycle_tick;
  logic [CH-1:0] clr;
  logic          rd_req;
  logic [IW-1:0] rd_idx;
  logic          rd_ready;

  logic [CH-1:0] ovf0, ovf1;
  logic          vld0, vld1;
  logic [W-1:0]  dat0, dat1;
  logic          err0, err1;

`ifdef CYCCNT_THRESH_EN
  logic [W-1:0]  thresh;
  logic [CH-1:0] alarm0, alarm1;
  logic [CH-1:0] alarm_m [2];
`endif

  int   cnt_m [2][CH];
  bit   ovf_m [2][CH];
  bit   busy_m;
  exp_t sb [$];
  exp_t cur;
  bit   seen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_cycle_counter #(
    .CHANNELS(CH), .WIDTH(W), .SATURATE(0), .IDX_W(IW)
  ) u_wrap (
    .clk(clk), .rst(rst),
    .cycle_tick(cycle_tick), .clr(clr), .ovf(ovf0),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(vld0),
    .rd_ready(rd_ready), .rd_data(dat0), .rd_err(err0)
`ifdef CYCCNT_THRESH_EN
    , .thresh(thresh), .alarm(alarm0)
`endif
  );

  multi_cycle_counter #(
    .CHANNELS(CH), .WIDTH(W), .SATURATE(1), .IDX_W(IW)
  ) u_sat (
    .clk(clk), .rst(rst),
    .cycle_tick(cycle_tick), .clr(clr), .ovf(ovf1),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_valid(vld1),
    .rd_ready(rd_ready), .rd_data(dat1), .rd_err(err1)
`ifdef CYCCNT_THRESH_EN
    , .thresh(thresh), .alarm(alarm1)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ovf_vec(input int s);
    int v = 0;
    for (int c = 0; c < CH; c++) if (ovf_m[s][c]) v |= (1 << c);
    return v;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < CH; c++) begin
        cnt_m[s][c] = 0;
        ovf_m[s][c] = 0;
      end
    busy_m = 0;
    sb.delete();
`ifdef CYCCNT_THRESH_EN
    alarm_m[0] = '0;
    alarm_m[1] = '0;
`endif
  endtask

  // Drive one cycle of inputs and advance the model to the next edge.
  task automatic step(input logic [CH-1:0] tk, input logic [CH-1:0] cl,
                      input logic rq, input logic [IW-1:0] ix,
                      input logic rdy);
    exp_t e;
    int   ii;
    @(negedge clk);
    cycle_tick = tk;
    clr        = cl;
    rd_req     = rq;
    rd_idx     = ix;
    rd_ready   = rdy;
    ii = int'(ix);
`ifdef CYCCNT_THRESH_EN
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < CH; c++)
        alarm_m[s][c] = !cl[c] && (thresh != 0) && (cnt_m[s][c] >= int'(thresh));
`endif
    if (!busy_m) begin
      if (rq) begin
        e.err = (ii >= CH);
        e.d0  = e.err ? 0 : cnt_m[0][ii];
        e.d1  = e.err ? 0 : cnt_m[1][ii];
        sb.push_back(e);
        busy_m = 1;
      end
    end else if (rdy) begin
      busy_m = 0;
    end
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < CH; c++) begin
        if (cl[c]) begin
          cnt_m[s][c] = 0;
          ovf_m[s][c] = 0;
        end else if (tk[c]) begin
          if (cnt_m[s][c] == MAXV) begin
            ovf_m[s][c] = 1;
            cnt_m[s][c] = (s == 1) ? MAXV : 0;
          end else begin
            cnt_m[s][c] = cnt_m[s][c] + 1;
          end
        end
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    cycle_tick = '0;
    clr        = '0;
    rd_req     = 1'b0;
    rd_ready   = 1'b0;
    #1;
    chk("rst_valid0", int'(vld0), 0);
    chk("rst_valid1", int'(vld1), 0);
    chk("rst_ovf0", int'(ovf0), 0);
    chk("rst_ovf1", int'(ovf1), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic rd(input logic [IW-1:0] ix);
    step('0, '0, 1'b1, ix, 1'b0);
    step('0, '0, 1'b0, ix, 1'b1);
  endtask

  // Monitor: compare every sample; pop once per presented response.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("ovf_wrap", int'(ovf0), ovf_vec(0));
      chk("ovf_sat", int'(ovf1), ovf_vec(1));
      chk("valid_wrap", int'(vld0), int'(busy_m));
      chk("valid_sat", int'(vld1), int'(busy_m));
`ifdef CYCCNT_THRESH_EN
      chk("alarm_wrap", int'(alarm0), int'(alarm_m[0]));
      chk("alarm_sat", int'(alarm1), int'(alarm_m[1]));
`endif
      if (vld0) begin
        if (!seen) begin
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow: got response with empty queue at %0t", $time);
          end else begin
            cur = sb.pop_front();
          end
          seen = 1;
        end
        chk("data_wrap", int'(dat0), cur.d0);
        chk("data_sat", int'(dat1), cur.d1);
        chk("err_wrap", int'(err0), int'(cur.err));
        chk("err_sat", int'(err1), int'(cur.err));
      end else begin
        seen = 0;
      end
    end else begin
      seen = 0;
    end
  end

  initial begin
    rst        = 1'b1;
    cycle_tick = '0;
    clr        = '0;
    rd_req     = 1'b0;
    rd_idx     = '0;
    rd_ready   = 1'b0;
    seen       = 0;
    cur        = '{0, 0, 0};
`ifdef CYCCNT_THRESH_EN
    thresh     = 4'd3;
`endif
    model_reset();
    #12;
    chk("init_valid", int'(vld0), 0);
    chk("init_ovf", int'(ovf0), 0);
    @(negedge clk);
    rst = 1'b0;

    // Five ticks on ch2, then a read held for three cycles under ticks.
    for (int k = 0; k < 5; k++) step(4'b0100, '0, 1'b0, '0, 1'b0);
    step('0, '0, 1'b1, 3'd2, 1'b0);
    for (int k = 0; k < 3; k++) step(4'b0100, '0, 1'b0, 3'd2, 1'b0);
    step('0, '0, 1'b0, 3'd2, 1'b1);
    idle(1);

    // Wrap vs saturate: 16 then 4 more ticks on ch0, then clear.
    for (int k = 0; k < 16; k++) step(4'b0001, '0, 1'b0, '0, 1'b1);
    rd(3'd0);
    for (int k = 0; k < 4; k++) step(4'b0001, '0, 1'b0, '0, 1'b1);
    rd(3'd0);
    step('0, 4'b0001, 1'b0, '0, 1'b1);
    rd(3'd0);

    // Clear wins over tick at count 7; then all channels tick together.
    step('0, 4'b0010, 1'b0, '0, 1'b1);
    for (int k = 0; k < 7; k++) step(4'b0010, '0, 1'b0, '0, 1'b1);
    step(4'b0010, 4'b0010, 1'b0, '0, 1'b1);
    rd(3'd1);
    step(4'b1111, '0, 1'b0, '0, 1'b1);
    for (int k = 0; k < CH; k++) rd(IW'(k));

    // Out-of-range index, then back-to-back reads with ready high.
    rd(3'd5);
    for (int k = 0; k < 8; k++) step('0, '0, 1'b1, IW'(k), 1'b1);
    idle(2);

`ifdef CYCCNT_THRESH_EN
    step('0, 4'b1000, 1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) step(4'b1000, '0, 1'b0, '0, 1'b1);
    idle(2);
    thresh = '0;
    idle(2);
    thresh = 4'd3;
`endif

    // Reset during a held response and mid-count.
    for (int k = 0; k < 3; k++) step(4'b1111, '0, 1'b0, '0, 1'b1);
    step('0, '0, 1'b1, 3'd1, 1'b0);
    step('0, '0, 1'b0, 3'd1, 1'b0);
    do_reset();
    for (int k = 0; k < CH; k++) rd(IW'(k));

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [CH-1:0] tk, cl;
      logic          rq, rdy;
      logic [IW-1:0] ix;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        tk  = CH'($urandom);
        cl  = ($urandom_range(0, 15) == 0) ? CH'($urandom) : '0;
        rq  = $urandom_range(0, 2) != 0;
        ix  = ($urandom_range(0, 7) == 0) ? IW'($urandom_range(4, 7))
                                          : IW'($urandom_range(0, 3));
        rdy = $urandom_range(0, 3) != 0;
`ifdef CYCCNT_THRESH_EN
        if ($urandom_range(0, 99) == 0) thresh = W'($urandom);
`endif
        step(tk, cl, rq, ix, rdy);
      end
    end

    idle(4);
    @(posedge clk);
    #2;
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
